// File: rtl/data_path_pkg.sv
// data_path shared definitions
// ALU opcodes, MDR mux selects, IR field positions
package data_path_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    localparam logic [1:0] MDR_SEL_BUS  = 2'b00;
    localparam logic [1:0] MDR_SEL_MEM  = 2'b01;
    localparam logic [1:0] MDR_SEL_IMM  = 2'b10;
    localparam logic [1:0] MDR_SEL_ZERO = 2'b11;

    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_MSB  = 18;

    function automatic logic [31:0] sext_c(input logic [31:0] ir);
        return {{(31 - IR_C_MSB){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// data_path ALU: Y op bus, 64-bit combinational result
// High word only carries MUL product and DIV remainder
module data_path_alu
    import data_path_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic        i_inc,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result
);

    logic [4:0]         w_sh;
    logic signed [63:0] w_prod;
    logic signed [31:0] w_quo;
    logic signed [31:0] w_rem;
    logic               w_bzero;

    assign w_sh    = i_b[4:0];
    assign w_bzero = (i_b == 32'd0);
    assign w_prod  = $signed({{32{i_a[31]}}, i_a}) *
                     $signed({{32{i_b[31]}}, i_b});
    assign w_quo   = w_bzero ? 32'sd0 : $signed(i_a) / $signed(i_b);
    assign w_rem   = w_bzero ? 32'sd0 : $signed(i_a) % $signed(i_b);

    // Opcode decode; IncPc forces bus + 1 regardless of opcode
    always_comb begin
        o_result = '0;
        if (i_inc) begin
            o_result[31:0] = i_b + 32'd1;
        end else begin
            case (i_op)
                ALU_AND:  o_result[31:0] = i_a & i_b;
                ALU_OR:   o_result[31:0] = i_a | i_b;
                ALU_ADD:  o_result[31:0] = i_a + i_b;
                ALU_SUB:  o_result[31:0] = i_a - i_b;
                ALU_SHR:  o_result[31:0] = i_a >> w_sh;
                ALU_SHRA: o_result[31:0] = $signed(i_a) >>> w_sh;
                ALU_SHL:  o_result[31:0] = i_a << w_sh;
                ALU_ROR:  o_result[31:0] = (i_a >> w_sh) |
                              (i_a << (6'd32 - {1'b0, w_sh}));
                ALU_ROL:  o_result[31:0] = (i_a << w_sh) |
                              (i_a >> (6'd32 - {1'b0, w_sh}));
                ALU_MUL:  o_result = w_prod;
                ALU_DIV:  o_result = {w_rem, w_quo};
                ALU_NEG:  o_result[31:0] = -i_b;
                ALU_NOT:  o_result[31:0] = ~i_b;
                default:  o_result = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_path.sv
// data_path: single-bus 32-bit datapath with register file,
// special registers, ALU, I/O ports and word-addressed RAM
module data_path
    import data_path_pkg::*;
#(
    parameter string INIT_FILE = "mem_init.hex",
    parameter int    MEM_DEPTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InportData,
    input  logic [31:0] Immediate,
    input  logic        PCout, Zlowout, Zhighout, MDRout,
    input  logic        HIout, LOout, InPortout, Cout, OutPortout,
    input  logic        MARin, PCin, MDRin, IRin, Yin,
    input  logic        HIin, LOin, OutPortin, InPortin,
    input  logic        Zin, Zlowin, Zhighin,
    input  logic        read, write, IncPc,
    input  logic [1:0]  mdr_read,
    input  logic [3:0]  control,
    input  logic        GRA, GRB, GRC, Rin, Rout, BAout,
    output logic [31:0] R0Val, R1Val, R2Val, R3Val,
    output logic [31:0] R4Val, R5Val, R6Val, R7Val,
    output logic [31:0] R8Val, R9Val, R10Val, R11Val,
    output logic [31:0] R12Val, R13Val, R14Val, R15Val,
    output logic [31:0] IRval, MDRval, YVal, PCVal, MAR_D,
    output logic [31:0] bus, mux_data_out, R0TempOut,
    output logic [31:0] C_sign_extended,
    output logic [31:0] InPort_D, OutPort_D, mdatain,
    output logic [31:0] ZVal1, ZVal2, ALUVal_D1, ALUVal_D2,
    output logic [15:0] Rin_Select, Rout_Select
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] r_gpr [16];
    logic [31:0] r_pc, r_ir, r_mar, r_mdr;
    logic [31:0] r_hi, r_lo, r_y, r_inport, r_outport;
    logic [63:0] r_z;
    logic [31:0] r_mem [MEM_DEPTH];

    logic [3:0]  w_idx;
    logic [15:0] w_dec, w_rin_sel, w_rout_sel;
    logic [31:0] w_bus, w_mdr_mux, w_csext, w_r0_gated, w_mdatain;
    logic [63:0] w_alu;
    logic [AW-1:0] w_addr;
    logic        w_unused;

    assign w_unused = &{1'b0, OutPortout};

    assign w_idx = ({4{GRA}} & r_ir[IR_RA_LSB +: 4]) |
                   ({4{GRB}} & r_ir[IR_RB_LSB +: 4]) |
                   ({4{GRC}} & r_ir[IR_RC_LSB +: 4]);
    assign w_dec      = 16'd1 << w_idx;
    assign w_rin_sel  = w_dec & {16{Rin}};
    assign w_rout_sel = w_dec & {16{Rout | BAout}};

    // BAout makes R0 read as zero for base+offset addressing
    assign w_r0_gated = BAout ? 32'd0 : r_gpr[0];
    assign w_csext    = sext_c(r_ir);
    assign w_addr     = r_mar[AW-1:0];
    assign w_mdatain  = read ? r_mem[w_addr] : 32'd0;

    // Bus source mux; later assignments override, lowest index wins
    always_comb begin
        w_bus = '0;
        if (Cout)      w_bus = w_csext;
        if (InPortout) w_bus = r_inport;
        if (MDRout)    w_bus = r_mdr;
        if (PCout)     w_bus = r_pc;
        if (Zlowout)   w_bus = r_z[31:0];
        if (Zhighout)  w_bus = r_z[63:32];
        if (LOout)     w_bus = r_lo;
        if (HIout)     w_bus = r_hi;
        for (int i = 15; i >= 1; i--) begin
            if (w_rout_sel[i]) w_bus = r_gpr[i];
        end
        if (w_rout_sel[0]) w_bus = w_r0_gated;
    end

    // MDR input select
    always_comb begin
        w_mdr_mux = '0;
        unique case (mdr_read)
            MDR_SEL_BUS:  w_mdr_mux = w_bus;
            MDR_SEL_MEM:  w_mdr_mux = w_mdatain;
            MDR_SEL_IMM:  w_mdr_mux = Immediate;
            MDR_SEL_ZERO: w_mdr_mux = '0;
        endcase
    end

    data_path_alu u_alu (
        .i_op     (control),
        .i_inc    (IncPc),
        .i_a      (r_y),
        .i_b      (w_bus),
        .o_result (w_alu)
    );

    // Register loads from the bus; Zin takes precedence over halves
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
            r_pc      <= '0;
            r_ir      <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_inport  <= '0;
            r_outport <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_rin_sel[i]) r_gpr[i] <= w_bus;
            end
            if (PCin)      r_pc      <= w_bus;
            if (IRin)      r_ir      <= w_bus;
            if (MARin)     r_mar     <= w_bus;
            if (MDRin)     r_mdr     <= w_mdr_mux;
            if (HIin)      r_hi      <= w_bus;
            if (LOin)      r_lo      <= w_bus;
            if (Yin)       r_y       <= w_bus;
            if (InPortin)  r_inport  <= InportData;
            if (OutPortin) r_outport <= w_bus;
            if (Zin) begin
                r_z <= w_alu;
            end else begin
                if (Zlowin)  r_z[31:0]  <= w_alu[31:0];
                if (Zhighin) r_z[63:32] <= w_alu[63:32];
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (write) r_mem[w_addr] <= r_mdr;
    end

    assign R0Val  = r_gpr[0];
    assign R1Val  = r_gpr[1];
    assign R2Val  = r_gpr[2];
    assign R3Val  = r_gpr[3];
    assign R4Val  = r_gpr[4];
    assign R5Val  = r_gpr[5];
    assign R6Val  = r_gpr[6];
    assign R7Val  = r_gpr[7];
    assign R8Val  = r_gpr[8];
    assign R9Val  = r_gpr[9];
    assign R10Val = r_gpr[10];
    assign R11Val = r_gpr[11];
    assign R12Val = r_gpr[12];
    assign R13Val = r_gpr[13];
    assign R14Val = r_gpr[14];
    assign R15Val = r_gpr[15];

    assign IRval           = r_ir;
    assign MDRval          = r_mdr;
    assign YVal            = r_y;
    assign PCVal           = r_pc;
    assign MAR_D           = r_mar;
    assign bus             = w_bus;
    assign mux_data_out    = w_mdr_mux;
    assign R0TempOut       = w_r0_gated;
    assign C_sign_extended = w_csext;
    assign InPort_D        = r_inport;
    assign OutPort_D       = r_outport;
    assign mdatain         = w_mdatain;
    assign ZVal1           = r_z[31:0];
    assign ZVal2           = r_z[63:32];
    assign ALUVal_D1       = w_alu[31:0];
    assign ALUVal_D2       = w_alu[63:32];
    assign Rin_Select      = w_rin_sel;
    assign Rout_Select     = w_rout_sel;

endmodule

// File: tb/tb_data_path.sv
// data_path bench: scoreboard of expected values per step
// plus a table of ALU vectors
module tb_data_path;
    import data_path_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] InportData, Immediate;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        HIout, LOout, InPortout, Cout, OutPortout;
    logic        MARin, PCin, MDRin, IRin, Yin;
    logic        HIin, LOin, OutPortin, InPortin;
    logic        Zin, Zlowin, Zhighin;
    logic        read, write, IncPc;
    logic [1:0]  mdr_read;
    logic [3:0]  control;
    logic        GRA, GRB, GRC, Rin, Rout, BAout;
    logic [31:0] rv [16];
    logic [31:0] IRval, MDRval, YVal, PCVal, MAR_D;
    logic [31:0] bus, mux_data_out, R0TempOut, C_sign_extended;
    logic [31:0] InPort_D, OutPort_D, mdatain;
    logic [31:0] ZVal1, ZVal2, ALUVal_D1, ALUVal_D2;
    logic [15:0] Rin_Select, Rout_Select;

    data_path #(.INIT_FILE(""), .MEM_DEPTH(512)) dut (
        .clk(clk), .reset(reset),
        .InportData(InportData), .Immediate(Immediate),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .InPortout(InPortout), .Cout(Cout), .OutPortout(OutPortout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
        .InPortin(InPortin), .Zin(Zin), .Zlowin(Zlowin),
        .Zhighin(Zhighin), .read(read), .write(write), .IncPc(IncPc),
        .mdr_read(mdr_read), .control(control),
        .GRA(GRA), .GRB(GRB), .GRC(GRC),
        .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .R0Val(rv[0]), .R1Val(rv[1]), .R2Val(rv[2]), .R3Val(rv[3]),
        .R4Val(rv[4]), .R5Val(rv[5]), .R6Val(rv[6]), .R7Val(rv[7]),
        .R8Val(rv[8]), .R9Val(rv[9]), .R10Val(rv[10]),
        .R11Val(rv[11]), .R12Val(rv[12]), .R13Val(rv[13]),
        .R14Val(rv[14]), .R15Val(rv[15]),
        .IRval(IRval), .MDRval(MDRval), .YVal(YVal), .PCVal(PCVal),
        .MAR_D(MAR_D), .bus(bus), .mux_data_out(mux_data_out),
        .R0TempOut(R0TempOut), .C_sign_extended(C_sign_extended),
        .InPort_D(InPort_D), .OutPort_D(OutPort_D), .mdatain(mdatain),
        .ZVal1(ZVal1), .ZVal2(ZVal2),
        .ALUVal_D1(ALUVal_D1), .ALUVal_D2(ALUVal_D2),
        .Rin_Select(Rin_Select), .Rout_Select(Rout_Select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_PC = 0, S_IR = 1, S_MAR = 2, S_MDR = 3;
    localparam int S_Y = 4, S_ZLO = 5, S_ZHI = 6, S_BUS = 7;
    localparam int S_ALO = 8, S_AHI = 9, S_MDAT = 10, S_INP = 11;
    localparam int S_OUTP = 12, S_CSX = 13, S_R0T = 14;
    localparam int S_RIN = 15, S_ROUT = 16, S_MUX = 17, S_R = 32;

    typedef struct {
        string       nm;
        int          sig;
        logic [31:0] v;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    exp_t sbq[$];
    vec_t tv[18];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] get_sig(input int s);
        if (s >= S_R) return rv[s - S_R];
        case (s)
            S_PC:   return PCVal;
            S_IR:   return IRval;
            S_MAR:  return MAR_D;
            S_MDR:  return MDRval;
            S_Y:    return YVal;
            S_ZLO:  return ZVal1;
            S_ZHI:  return ZVal2;
            S_BUS:  return bus;
            S_ALO:  return ALUVal_D1;
            S_AHI:  return ALUVal_D2;
            S_MDAT: return mdatain;
            S_INP:  return InPort_D;
            S_OUTP: return OutPort_D;
            S_CSX:  return C_sign_extended;
            S_R0T:  return R0TempOut;
            S_RIN:  return {16'd0, Rin_Select};
            S_ROUT: return {16'd0, Rout_Select};
            S_MUX:  return mux_data_out;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_v(input string nm, input int s,
                            input logic [31:0] v);
        exp_t e;
        e.nm = nm; e.sig = s; e.v = v;
        sbq.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] got;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            got = get_sig(e.sig);
            n_checks++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s got=%h exp=%h t=%0t",
                         e.nm, got, e.v, $time);
            end
        end
    endtask

    task automatic idle();
        {PCout, Zlowout, Zhighout, MDRout, HIout, LOout} = '0;
        {InPortout, Cout, OutPortout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin} = '0;
        {OutPortin, InPortin, Zin, Zlowin, Zhighin} = '0;
        {read, write, IncPc, GRA, GRB, GRC, Rin, Rout, BAout} = '0;
        mdr_read = MDR_SEL_BUS;
        control  = ALU_AND;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check();
        idle();
    endtask

    task automatic comb();
        #1;
        check();
    endtask

    task automatic set_mdr(input logic [31:0] v);
        Immediate = v;
        mdr_read  = MDR_SEL_IMM;
        MDRin     = 1'b1;
        tick();
    endtask

    task automatic set_mar(input logic [31:0] v);
        set_mdr(v);
        MDRout = 1'b1; MARin = 1'b1;
        tick();
    endtask

    task automatic set_y(input logic [31:0] v);
        set_mdr(v);
        MDRout = 1'b1; Yin = 1'b1;
        tick();
    endtask

    task automatic set_ir(input logic [31:0] v);
        set_mdr(v);
        MDRout = 1'b1; IRin = 1'b1;
        tick();
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
        set_mar(a);
        set_mdr(d);
        write = 1'b1;
        tick();
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i < 16; i++) expect_v($sformatf("%s_R%0d", tag, i), S_R + i, 32'd0);
        expect_v({tag, "_PC"},  S_PC,  32'd0);
        expect_v({tag, "_IR"},  S_IR,  32'd0);
        expect_v({tag, "_MAR"}, S_MAR, 32'd0);
        expect_v({tag, "_MDR"}, S_MDR, 32'd0);
        expect_v({tag, "_Y"},   S_Y,   32'd0);
        expect_v({tag, "_ZLO"}, S_ZLO, 32'd0);
        expect_v({tag, "_ZHI"}, S_ZHI, 32'd0);
        expect_v({tag, "_INP"}, S_INP, 32'd0);
        expect_v({tag, "_OUTP"}, S_OUTP, 32'd0);
    endtask

    initial begin
        tv[0]  = '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h0};
        tv[1]  = '{ALU_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 32'h0};
        tv[2]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0};
        tv[3]  = '{ALU_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 32'h0};
        tv[4]  = '{ALU_SHR,  32'h8000_0000, 32'd4,         32'h0800_0000, 32'h0};
        tv[5]  = '{ALU_SHRA, 32'h8000_0000, 32'd4,         32'hF800_0000, 32'h0};
        tv[6]  = '{ALU_SHL,  32'h0000_0001, 32'd31,        32'h8000_0000, 32'h0};
        tv[7]  = '{ALU_SHL,  32'h0000_0001, 32'h21,        32'h0000_0002, 32'h0};
        tv[8]  = '{ALU_ROR,  32'h0000_0001, 32'd1,         32'h8000_0000, 32'h0};
        tv[9]  = '{ALU_ROR,  32'h1234_5678, 32'd32,        32'h1234_5678, 32'h0};
        tv[10] = '{ALU_ROL,  32'h8000_0001, 32'd4,         32'h0000_0018, 32'h0};
        tv[11] = '{ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0};
        tv[12] = '{ALU_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h1};
        tv[13] = '{ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tv[14] = '{ALU_DIV,  32'd100,       32'd0,         32'h0,         32'h0};
        tv[15] = '{ALU_NEG,  32'hAAAA_AAAA, 32'd5,         32'hFFFF_FFFB, 32'h0};
        tv[16] = '{ALU_NOT,  32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 32'h0};
        tv[17] = '{4'd13,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0};

        idle();
        InportData = 32'h0;
        Immediate  = 32'h0;
        reset      = 1'b0;
        expect_all_zero("rst");
        comb();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        mem_write(32'd4, 32'h0080_0023);
        mem_write(32'd35, 32'hDEAD_BEEF);

        // PC load through MDR
        expect_v("imm_mdr", S_MDR, 32'd4);
        set_mdr(32'd4);
        MDRout = 1'b1; PCin = 1'b1;
        expect_v("pc_load", S_PC, 32'd4);
        tick();

        // T0
        PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1;
        expect_v("t0_bus", S_BUS, 32'd4);
        expect_v("t0_alu", S_ALO, 32'd5);
        comb();
        expect_v("t0_mar", S_MAR, 32'd4);
        expect_v("t0_z", S_ZLO, 32'd5);
        tick();
        // T1
        Zlowout = 1'b1; PCin = 1'b1; read = 1'b1;
        mdr_read = MDR_SEL_MEM; MDRin = 1'b1;
        expect_v("t1_mdat", S_MDAT, 32'h0080_0023);
        comb();
        expect_v("t1_pc", S_PC, 32'd5);
        expect_v("t1_mdr", S_MDR, 32'h0080_0023);
        tick();
        // T2
        MDRout = 1'b1; IRin = 1'b1;
        expect_v("t2_ir", S_IR, 32'h0080_0023);
        tick();
        expect_v("c_sext", S_CSX, 32'h23);
        comb();

        // T3: Y <= base (Rb = R0 -> 0)
        GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        expect_v("t3_rout", S_ROUT, 32'h1);
        expect_v("t3_bus", S_BUS, 32'd0);
        comb();
        expect_v("t3_y", S_Y, 32'd0);
        tick();
        // T4
        Cout = 1'b1; control = ALU_ADD; Zlowin = 1'b1;
        expect_v("t4_alu", S_ALO, 32'd35);
        comb();
        expect_v("t4_z", S_ZLO, 32'd35);
        tick();
        // T5 (Ra = 1)
        Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        expect_v("t5_rin", S_RIN, 32'h2);
        comb();
        expect_v("t5_r1", S_R + 1, 32'd35);
        tick();
        Zlowout = 1'b1; MARin = 1'b1;
        expect_v("ld_mar", S_MAR, 32'd35);
        tick();
        read = 1'b1; mdr_read = MDR_SEL_MEM; MDRin = 1'b1;
        expect_v("ld_mdr", S_MDR, 32'hDEAD_BEEF);
        tick();
        MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        expect_v("ld_r1", S_R + 1, 32'hDEAD_BEEF);
        tick();

        // R0 gating under BAout
        set_mdr(32'd7);
        MDRout = 1'b1; GRB = 1'b1; Rin = 1'b1;
        expect_v("r0_load", S_R + 0, 32'd7);
        tick();
        GRB = 1'b1; BAout = 1'b1;
        expect_v("ba_bus", S_BUS, 32'd0);
        expect_v("ba_r0t", S_R0T, 32'd0);
        comb();
        BAout = 1'b0; Rout = 1'b1;
        expect_v("rout_bus", S_BUS, 32'd7);
        expect_v("rout_r0t", S_R0T, 32'd7);
        comb();
        PCout = 1'b1;
        expect_v("prio_reg", S_BUS, 32'd7);
        comb();
        idle();
        PCout = 1'b1; MDRout = 1'b1;
        expect_v("prio_pc", S_BUS, 32'd5);
        comb();
        idle();

        // MUL and Z half-loads
        set_y(32'hFFFF_FFFE);
        set_mdr(32'd3);
        MDRout = 1'b1; control = ALU_MUL; Zin = 1'b1;
        expect_v("mul_hi", S_ZHI, 32'hFFFF_FFFF);
        expect_v("mul_lo", S_ZLO, 32'hFFFF_FFFA);
        tick();
        set_mdr(32'd1);
        MDRout = 1'b1; control = ALU_ADD; Zin = 1'b1;
        expect_v("add_hi", S_ZHI, 32'h0);
        expect_v("add_lo", S_ZLO, 32'hFFFF_FFFF);
        tick();
        set_mdr(32'd3);
        MDRout = 1'b1; control = ALU_MUL; Zhighin = 1'b1;
        expect_v("zh_hi", S_ZHI, 32'hFFFF_FFFF);
        expect_v("zh_lo", S_ZLO, 32'hFFFF_FFFF);
        tick();
        MDRout = 1'b1; control = ALU_AND; Zlowin = 1'b1;
        expect_v("zl_hi", S_ZHI, 32'hFFFF_FFFF);
        expect_v("zl_lo", S_ZLO, 32'd2);
        tick();
        MDRout = 1'b1; control = ALU_MUL; Zin = 1'b1; Zlowin = 1'b1;
        expect_v("zin_hi", S_ZHI, 32'hFFFF_FFFF);
        expect_v("zin_lo", S_ZLO, 32'hFFFF_FFFA);
        tick();

        // IncPc overrides opcode
        set_mdr(32'd9);
        MDRout = 1'b1; control = ALU_MUL; IncPc = 1'b1;
        expect_v("inc_lo", S_ALO, 32'd10);
        expect_v("inc_hi", S_AHI, 32'd0);
        comb();
        idle();

        // Ports, HI, LO
        InportData = 32'hCAFE_F00D; InPortin = 1'b1;
        expect_v("inport", S_INP, 32'hCAFE_F00D);
        tick();
        InPortout = 1'b1; HIin = 1'b1;
        tick();
        HIout = 1'b1; OutPortin = 1'b1;
        expect_v("hi_bus", S_BUS, 32'hCAFE_F00D);
        comb();
        expect_v("outport", S_OUTP, 32'hCAFE_F00D);
        tick();
        set_mdr(32'h0000_1234);
        MDRout = 1'b1; LOin = 1'b1;
        tick();
        LOout = 1'b1;
        expect_v("lo_bus", S_BUS, 32'h0000_1234);
        comb();
        idle();

        // Simultaneous read and write
        set_mar(32'd35);
        set_mdr(32'h1234_5678);
        write = 1'b1; read = 1'b1; mdr_read = MDR_SEL_MEM; MDRin = 1'b1;
        expect_v("rw_mdr", S_MDR, 32'hDEAD_BEEF);
        tick();
        read = 1'b1;
        expect_v("rw_mdat", S_MDAT, 32'h1234_5678);
        comb();
        read = 1'b0;
        expect_v("noread", S_MDAT, 32'h0);
        comb();
        mdr_read = MDR_SEL_ZERO; MDRin = 1'b1;
        expect_v("mux_zero", S_MUX, 32'h0);
        comb();
        expect_v("mdr_zero", S_MDR, 32'h0);
        tick();
        PCout = 1'b1; mdr_read = MDR_SEL_BUS; MDRin = 1'b1;
        expect_v("mdr_bus", S_MDR, 32'd5);
        tick();

        // Field select / encode
        set_ir(32'h010A_0000);
        GRA = 1'b1; Rin = 1'b1;
        expect_v("sel_a", S_RIN, 32'h0004);
        comb();
        GRA = 1'b0; GRB = 1'b1;
        expect_v("sel_b", S_RIN, 32'h0002);
        comb();
        GRB = 1'b0; GRC = 1'b1;
        expect_v("sel_c", S_RIN, 32'h0010);
        expect_v("sel_c_out", S_ROUT, 32'h0);
        comb();
        GRC = 1'b0; GRA = 1'b1; GRB = 1'b1; Rin = 1'b0; Rout = 1'b1;
        expect_v("sel_or", S_ROUT, 32'h0008);
        expect_v("sel_or_in", S_RIN, 32'h0);
        comb();
        idle();
        set_ir(32'h0007_FFFF);
        Cout = 1'b1;
        expect_v("c_neg", S_CSX, 32'hFFFF_FFFF);
        expect_v("c_bus", S_BUS, 32'hFFFF_FFFF);
        comb();
        idle();

        // ALU vector table
        for (int i = 0; i < 18; i++) begin
            set_y(tv[i].a);
            set_mdr(tv[i].b);
            MDRout = 1'b1; control = tv[i].op; Zin = 1'b1;
            expect_v($sformatf("alu%0d_lo", i), S_ALO, tv[i].lo);
            expect_v($sformatf("alu%0d_hi", i), S_AHI, tv[i].hi);
            comb();
            expect_v($sformatf("z%0d_lo", i), S_ZLO, tv[i].lo);
            expect_v($sformatf("z%0d_hi", i), S_ZHI, tv[i].hi);
            tick();
        end

        // Mid-run asynchronous reset
        set_mar(32'd35);
        InPortin = 1'b1;
        tick();
        OutPortin = 1'b1; InPortout = 1'b1;
        tick();
        #2 reset = 1'b0;
        expect_all_zero("mid");
        comb();
        #1 reset = 1'b1;
        set_mar(32'd35);
        read = 1'b1;
        expect_v("mem_keep", S_MDAT, 32'h1234_5678);
        comb();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
